// File: rtl/bp_be_fe_queue_buffer.sv
// Checkpointing FE->BE packet queue: entries are offered speculatively at rptr,
// retired at cptr, and can be replayed (roll) or flushed (clr) before retirement.
module bp_be_fe_queue_buffer
  #(parameter int bp_params_p = 0  // 0 selects e_bp_inv_cfg
    , parameter int els_p = 8
    , localparam int fe_queue_width_lp = (bp_params_p == 0) ? 72 : 120
    , localparam int ptr_width_lp = $clog2(els_p) + 1
    )
  (input  logic                         clk_i
   , input  logic                       reset_i

   , input  logic [fe_queue_width_lp-1:0] fe_queue_i
   , input  logic                       fe_queue_v_i
   , output logic                       fe_queue_ready_o

   , output logic [fe_queue_width_lp-1:0] fe_queue_o
   , output logic                       fe_queue_v_o
   , input  logic                       fe_queue_yumi_i

   , input  logic                       deq_v_i
   , input  logic                       roll_v_i
   , input  logic                       clr_v_i
   );

  localparam int idx_width_lp = ptr_width_lp - 1;

  logic [ptr_width_lp-1:0] wptr_reg, wptr_next;
  logic [ptr_width_lp-1:0] rptr_reg, rptr_next;
  logic [ptr_width_lp-1:0] cptr_reg, cptr_next;
  logic [ptr_width_lp-1:0] cptr_deq;
  logic [ptr_width_lp-1:0] occupancy;
  logic                    full;
  logic                    enq;

  logic [fe_queue_width_lp-1:0] mem_reg [els_p];

  // The wrap bit makes occupancy == els_p distinguishable from empty.
  assign occupancy        = wptr_reg - cptr_reg;
  assign full             = (occupancy == ptr_width_lp'(els_p));
  assign fe_queue_ready_o = ~full & ~reset_i;
  assign enq              = fe_queue_v_i & fe_queue_ready_o;

  assign fe_queue_v_o = (wptr_reg != rptr_reg);
  assign fe_queue_o   = mem_reg[rptr_reg[idx_width_lp-1:0]];

  assign cptr_deq = deq_v_i ? cptr_reg + 1'b1 : cptr_reg;

  always_comb begin
    wptr_next = wptr_reg;
    rptr_next = rptr_reg;
    cptr_next = cptr_deq;
    if (clr_v_i) begin
      wptr_next = '0;
      rptr_next = '0;
      cptr_next = '0;
    end else begin
      if (enq)
        wptr_next = wptr_reg + 1'b1;
      // Roll rewinds to the post-commit pointer so a same-cycle deq is honoured.
      if (roll_v_i)
        rptr_next = cptr_deq;
      else if (fe_queue_yumi_i)
        rptr_next = rptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
      cptr_reg <= '0;
    end else begin
      wptr_reg <= wptr_next;
      rptr_reg <= rptr_next;
      cptr_reg <= cptr_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < els_p; gi++) begin : g_entry
      always_ff @(posedge clk_i) begin
        if (enq & ~clr_v_i & (wptr_reg[idx_width_lp-1:0] == idx_width_lp'(gi)))
          mem_reg[gi] <= fe_queue_i;
      end
    end
  endgenerate

  a_yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i)
    fe_queue_yumi_i |-> fe_queue_v_o);
  a_deq_legal: assert property (@(posedge clk_i) disable iff (reset_i)
    deq_v_i |-> (cptr_reg != rptr_reg));

endmodule

// File: tb/tb_bp_be_fe_queue_buffer.sv
// Scoreboard bench for bp_be_fe_queue_buffer: an in-order list of uncommitted
// packets plus a read index predicts ready/valid/data every cycle.
module tb_bp_be_fe_queue_buffer;

  localparam int W    = 72;
  localparam int ELS  = 8;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic [W-1:0] fe_queue_i;
  logic         fe_queue_v_i;
  logic         fe_queue_ready_o;
  logic [W-1:0] fe_queue_o;
  logic         fe_queue_v_o;
  logic         fe_queue_yumi_i;
  logic         deq_v_i;
  logic         roll_v_i;
  logic         clr_v_i;

  bp_be_fe_queue_buffer #(.bp_params_p(0), .els_p(ELS)) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .fe_queue_i       (fe_queue_i),
    .fe_queue_v_i     (fe_queue_v_i),
    .fe_queue_ready_o (fe_queue_ready_o),
    .fe_queue_o       (fe_queue_o),
    .fe_queue_v_o     (fe_queue_v_o),
    .fe_queue_yumi_i  (fe_queue_yumi_i),
    .deq_v_i          (deq_v_i),
    .roll_v_i         (roll_v_i),
    .clr_v_i          (clr_v_i)
  );

  always #5 clk_i = ~clk_i;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc_n        = 0;

  // Uncommitted packets, oldest first; sb_rd indexes the next one to offer.
  logic [W-1:0] sb_q [$];
  int           sb_rd = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc_n, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pk(input int i);
    logic [W-1:0] p;
    p = W'(32'hA500_0000 + i);
    p = p ^ (W'(i * 7 + 3) << 40);
    return p;
  endfunction

  // Drive one cycle, check outputs against the scoreboard, then update it.
  task automatic cyc(input bit rst, input bit v, input logic [W-1:0] d,
                     input bit y, input bit dq, input bit rl, input bit cl);
    bit exp_ready, exp_valid, enq;
    reset_i = rst; fe_queue_v_i = v; fe_queue_i = d;
    fe_queue_yumi_i = y; deq_v_i = dq; roll_v_i = rl; clr_v_i = cl;
    #1;
    exp_ready = !rst && (sb_q.size() < ELS);
    exp_valid = (sb_rd < sb_q.size());
    check_eq("ready", W'(fe_queue_ready_o), W'(exp_ready));
    check_eq("valid", W'(fe_queue_v_o), W'(exp_valid));
    if (exp_valid)
      check_eq("data", fe_queue_o, sb_q[sb_rd]);
    $display("cyc %0d rst=%0b v=%0b y=%0b dq=%0b roll=%0b clr=%0b rdy=%0b vo=%0b out=%h",
             cyc_n, rst, v, y, dq, rl, cl, fe_queue_ready_o, fe_queue_v_o, fe_queue_o);
    enq = v && exp_ready;
    if (rst || cl) begin
      sb_q.delete();
      sb_rd = 0;
    end else begin
      if (enq) sb_q.push_back(d);
      if (dq) begin
        void'(sb_q.pop_front());
        sb_rd--;
      end
      if (rl) sb_rd = 0;
      else if (y) sb_rd++;
    end
    @(posedge clk_i);
    #1;
    cyc_n++;
  endtask

  task automatic idle();
    cyc(0, 0, '0, 0, 0, 0, 0);
  endtask

  initial begin
    reset_i = 1'b1; fe_queue_v_i = 0; fe_queue_i = '0;
    fe_queue_yumi_i = 0; deq_v_i = 0; roll_v_i = 0; clr_v_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    cyc(1, 0, '0, 0, 0, 0, 0);
    idle();

    // Fill: nine offered, eight accepted
    for (int i = 0; i < 9; i++) cyc(0, 1, pk(i), 0, 0, 0, 0);
    idle();

    // Replay
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, 1, 0, 0, 0);
    cyc(0, 0, '0, 0, 0, 1, 0);
    cyc(0, 0, '0, 1, 0, 0, 0);
    cyc(0, 0, '0, 0, 1, 1, 0);
    idle();

    // Commit frees slots; read-but-uncommitted entries still count
    cyc(0, 1, pk(8), 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, '0, 1, 0, 0, 0);
    idle();
    cyc(0, 0, '0, 0, 1, 0, 0);
    cyc(0, 0, '0, 0, 1, 0, 0);
    cyc(0, 1, pk(20), 0, 0, 0, 0);
    cyc(0, 1, pk(21), 0, 0, 0, 0);
    cyc(0, 1, pk(22), 0, 0, 0, 0);
    cyc(0, 0, '0, 0, 0, 0, 1);
    idle();

    // Wrap: enq, yumi and deq every cycle
    for (int i = 0; i < 40; i++)
      cyc(0, 1, pk(100 + i), sb_rd < sb_q.size(), sb_rd > 0, 0, 0);
    for (int k = 0; k < 20 && sb_q.size() > 0; k++)
      cyc(0, 0, '0, sb_rd < sb_q.size(), sb_rd > 0, 0, 0);
    idle();

    // Flush drops a same-cycle enq
    for (int i = 0; i < 5; i++) cyc(0, 1, pk(200 + i), 0, 0, 0, 0);
    cyc(0, 0, '0, 1, 0, 0, 0);
    cyc(0, 1, pk(9), 0, 0, 0, 1);
    idle();
    cyc(0, 1, pk(210), 0, 0, 0, 0);
    idle();
    cyc(0, 0, '0, 0, 0, 0, 1);

    // Reset mid-stream
    for (int i = 0; i < 4; i++) cyc(0, 1, pk(300 + i), 0, 0, 0, 0);
    cyc(0, 0, '0, 1, 0, 0, 0);
    cyc(0, 0, '0, 1, 0, 0, 0);
    cyc(1, 1, pk(399), 0, 0, 0, 0);
    cyc(0, 1, pk(310), 0, 0, 0, 0);
    cyc(0, 0, '0, 1, 0, 0, 0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
